// File: rtl/cordic_gain_pkg.sv
// Shared definitions for the CORDIC gain-expansion datapath.
//   N_GAIN_TERMS : number of shift-add terms making up An ~= 1.646759033
//   GAIN_SHIFT   : right-shift amount of each term, applied in order
//   ACC_GUARD    : extra accumulator bits above the operand width
//   CNT_W        : term counter width (counts 0..N_GAIN_TERMS)
//   state_t      : sequencing FSM states
package cordic_gain_pkg;

  localparam int N_GAIN_TERMS = 8;
  localparam int ACC_GUARD    = 2;
  localparam int CNT_W        = 4;

  localparam int GAIN_SHIFT [0:N_GAIN_TERMS-1] = '{0, 1, 3, 6, 8, 9, 12, 15};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gain_expand_lane.sv
// One datapath lane of vec_gain_expand: operand register, per-term shift mux,
// accumulator and output narrowing.
// Build option: VEC_GAIN_SAT_EN selects saturating narrowing; without it the
// low CORDIC_WIDTH accumulator bits are kept (two's-complement wrap).
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears acc and dout)
//   load      : capture din, clear the accumulator
//   step      : add the term selected by sel into the accumulator
//   store     : narrow the accumulator into dout
//   sel       : index of the current gain term
//   din       : signed operand
//   dout      : signed result, held between stores
module gain_expand_lane
  import cordic_gain_pkg::*;
#(
  parameter int CORDIC_WIDTH = 22
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load,
  input  logic                           step,
  input  logic                           store,
  input  logic [2:0]                     sel,
  input  logic signed [CORDIC_WIDTH-1:0] din,
  output logic signed [CORDIC_WIDTH-1:0] dout
);

  localparam int AW = CORDIC_WIDTH + ACC_GUARD;

  logic signed [CORDIC_WIDTH-1:0] opnd_p0;
  logic signed [AW-1:0]           opnd_ext;
  logic signed [AW-1:0]           term;
  logic signed [AW-1:0]           acc_p1;

  function automatic logic signed [CORDIC_WIDTH-1:0] narrow(input logic signed [AW-1:0] a);
`ifdef VEC_GAIN_SAT_EN
    logic signed [AW-1:0] hi;
    logic signed [AW-1:0] lo;
    hi = {{(AW-CORDIC_WIDTH+1){1'b0}}, {(CORDIC_WIDTH-1){1'b1}}};
    lo = {{(AW-CORDIC_WIDTH+1){1'b1}}, {(CORDIC_WIDTH-1){1'b0}}};
    if (a > hi)
      return CORDIC_WIDTH'(hi);
    else if (a < lo)
      return CORDIC_WIDTH'(lo);
    else
      return CORDIC_WIDTH'(a);
`else
    return CORDIC_WIDTH'(a);
`endif
  endfunction

  // Operand capture; holds for the whole accumulation.
  always_ff @(posedge clk) begin
    if (load)
      opnd_p0 <= din;
  end

  // Floor-shift of the sign-extended operand: -1 contributes -1 per term.
  assign opnd_ext = {{ACC_GUARD{opnd_p0[CORDIC_WIDTH-1]}}, opnd_p0};
  assign term     = opnd_ext >>> GAIN_SHIFT[sel];

  // Accumulate one term per step, then narrow into the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p1 <= '0;
      dout   <= '0;
    end else begin
      if (load)
        acc_p1 <= '0;
      else if (step)
        acc_p1 <= acc_p1 + term;
      if (store)
        dout <= narrow(acc_p1);
    end
  end

endmodule

// File: rtl/vec_gain_expand.sv
// vec_gain_expand: multiplies (x,y) by the CORDIC gain An ~= 1.646759 using
// eight shift-add terms, one per clock, both lanes in parallel.
// Build option: VEC_GAIN_SAT_EN saturates the result instead of wrapping.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready only in IDLE)
//   x_in, y_in          : signed operands
//   out_valid/out_ready : result handshake, result held until accepted
//   x_out, y_out        : x_in*An, y_in*An (truncated)
// Timing: out_valid rises 9 clocks after the accepting edge; the FSM spends
// 8 ACC cycles adding terms and a 9th registering the narrowed result.
module vec_gain_expand
  import cordic_gain_pkg::*;
#(
  parameter int CORDIC_WIDTH = 22
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [CORDIC_WIDTH-1:0] x_in,
  input  logic signed [CORDIC_WIDTH-1:0] y_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [CORDIC_WIDTH-1:0] x_out,
  output logic signed [CORDIC_WIDTH-1:0] y_out
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_GAIN_TERMS);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             step;
  logic             store;

  assign load  = in_valid && in_ready;
  // cnt == LAST_CNT marks the extra cycle in which all terms are summed.
  assign step  = (state == ACC) && (cnt != LAST_CNT);
  assign store = (state == ACC) && (cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= ACC;
            cnt      <= '0;
            in_ready <= 1'b0;
          end
        end
        ACC: begin
          if (cnt == LAST_CNT) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  gain_expand_lane #(.CORDIC_WIDTH(CORDIC_WIDTH)) u_lane_x (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .step  (step),
    .store (store),
    .sel   (cnt[2:0]),
    .din   (x_in),
    .dout  (x_out)
  );

  gain_expand_lane #(.CORDIC_WIDTH(CORDIC_WIDTH)) u_lane_y (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .step  (step),
    .store (store),
    .sel   (cnt[2:0]),
    .din   (y_in),
    .dout  (y_out)
  );

endmodule

// File: tb/tb_vec_gain_expand.sv
// Self-checking bench for vec_gain_expand: directed cases plus random
// operands against an arithmetic reference of the eight floor terms.
module tb_vec_gain_expand;

  localparam int W = 22;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] x_in;
  logic signed [W-1:0] y_in;
  logic signed [W-1:0] x_out;
  logic signed [W-1:0] y_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int sh [8] = '{0, 1, 3, 6, 8, 9, 12, 15};

  vec_gain_expand #(.CORDIC_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // x*An as the sum of floor(x / 2^k) over the gain shifts, then narrowed.
  function automatic longint model(input longint a);
    longint s;
    longint d;
    longint q;
    longint maxv;
    s    = 0;
    maxv = (longint'(1) << (W-1)) - 1;
    for (int i = 0; i < 8; i++) begin
      d = longint'(1) << sh[i];
      q = a / d;
      if ((a % d) != 0 && a < 0) q = q - 1;
      s = s + q;
    end
`ifdef VEC_GAIN_SAT_EN
    if (s > maxv) s = maxv;
    if (s < -maxv - 1) s = -maxv - 1;
`else
    s = s & ((longint'(1) << W) - 1);
    if (s > maxv) s = s - (longint'(1) << W);
`endif
    return s;
  endfunction

  task automatic accept(input longint x, input longint y);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    x_in     = W'(x);
    y_in     = W'(y);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 9);
  endtask

  task automatic check_out(input string tag, input longint x, input longint y);
    chk({tag, "_x"}, x_out, model(x));
    chk({tag, "_y"}, y_out, model(y));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  initial begin
    logic signed [W-1:0] r;
    longint rx;
    longint ry;
    longint hx;
    longint hy;
    int     prev_cyc;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_in      = '0;
    y_in      = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_x_out", x_out, 0);
    chk("rst_y_out", y_out, 0);

    // Reference values quoted for the unit gain case.
    accept(65536, -65536);
    wait_out();
    chk("unit_x", x_out, 107922);
    chk("unit_y", y_out, -107922);
    release_out();

    accept(-1, -3);
    wait_out();
    chk("floor_x", x_out, -8);
    chk("floor_y", y_out, -11);
    release_out();

    accept(1500000, 0);
    wait_out();
`ifdef VEC_GAIN_SAT_EN
    chk("big_x", x_out, 2097151);
`else
    chk("big_x", x_out, -1724168);
`endif
    chk("big_y", y_out, 0);
    release_out();

    accept(-2097152, 2097151);
    wait_out();
    check_out("extreme", -2097152, 2097151);
    release_out();

    // Back-pressure: junk in_valid while busy, result held for 5 cycles.
    accept(123456, -777);
    in_valid = 1'b1;
    x_in     = W'(999);
    y_in     = W'(-999);
    wait_out();
    check_out("hold", 123456, -777);
    hx = x_out;
    hy = y_out;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_x", x_out, hx);
      chk("hold_y", y_out, hy);
      chk("hold_in_ready", in_ready, 0);
    end
    x_in      = W'(1000);
    y_in      = W'(-2000);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("ret_out_valid", out_valid, 0);
    chk("ret_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("second_taken", in_ready, 0);
    wait_out();
    check_out("second", 1000, -2000);
    release_out();

    // Reset while accumulating (cnt = 4) drops the operand.
    accept(54321, -54321);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_x_out", x_out, 0);
    chk("midrst_y_out", y_out, 0);
    chk("midrst_in_ready", in_ready, 1);
    accept(-40000, 31000);
    wait_out();
    check_out("after_rst", -40000, 31000);
    release_out();

    // Random back-to-back traffic with out_ready held high.
    out_ready = 1'b1;
    prev_cyc  = 0;
    for (int i = 0; i < 20; i++) begin
      r  = W'($urandom);
      rx = longint'(r);
      r  = W'($urandom);
      ry = longint'(r);
      accept(rx, ry);
      wait_out();
      check_out("rand", rx, ry);
      if (i > 0) chk("spacing_ge10", longint'((cyc - prev_cyc) >= 10), 1);
      prev_cyc = cyc;
      @(posedge clk); #1;
      chk("rand_drop", out_valid, 0);
    end
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
